// File: rtl/ysyx_22050499_axi_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22050499_axi_arbiter_pkg
//   Shared definitions for the two-master arbiter and its address decoder:
//   the arbiter FSM state encoding, the xbar_decode target codes, the default
//   CLINT window, and a helper that tests whether an address lies in a window.
// ----------------------------------------------------------------------------
package ysyx_22050499_axi_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AR    = 3'd1,
        ST_R     = 3'd2,
        ST_AW    = 3'd3,
        ST_B     = 3'd4,
        ST_ERR_R = 3'd5,
        ST_ERR_B = 3'd6
    } arb_state_t;

    // One-hot target codes driven on xbar_decode; all-zero means no target.
    localparam logic [3:0] DECODE_NONE  = 4'b0000;
    localparam logic [3:0] DECODE_CLINT = 4'b0001;

    localparam logic [31:0] CLINT_BASE_DEFAULT = 32'ha000_0048;
    localparam logic [31:0] CLINT_SIZE_DEFAULT = 32'd16;

    // Unsigned offset trick: when addr < base the subtraction wraps to a huge
    // value, so a single compare covers both window bounds on full 32 bits.
    function automatic logic in_window(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] size
    );
        logic [31:0] offset;
        offset = addr - base;
        return (offset < size);
    endfunction

endpackage

// File: rtl/ysyx_22050499_addr_decode.sv
// ----------------------------------------------------------------------------
// ysyx_22050499_addr_decode
//   Combinational address decoder for the downstream xbar.
//   Ports:
//     addr    in  32 : byte address of the request
//     decode  out 4  : one-hot target select (DECODE_CLINT) or DECODE_NONE
//     mapped  out 1  : high when some target claims the address
//   Further targets (SRAM, UART) are added here as extra windows/bits.
// ----------------------------------------------------------------------------
module ysyx_22050499_addr_decode
    import ysyx_22050499_axi_arbiter_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEFAULT,
    parameter logic [31:0] CLINT_SIZE = CLINT_SIZE_DEFAULT
) (
    input  logic [31:0] addr,
    output logic [3:0]  decode,
    output logic        mapped
);

    logic clint_hit;

    always_comb begin
        clint_hit = in_window(addr, CLINT_BASE, CLINT_SIZE);
        decode    = clint_hit ? DECODE_CLINT : DECODE_NONE;
        mapped    = (decode != DECODE_NONE);
    end

endmodule

// File: rtl/ysyx_22050499_axi_arbiter.sv
// ----------------------------------------------------------------------------
// ysyx_22050499_axi_arbiter
//   Shares one downstream port between the IFU (master 0, read-only) and the
//   LSU (master 1, read/write). One transaction is in flight at a time; the
//   captured address is decoded onto xbar_decode, and unmapped addresses are
//   answered locally (read data 0, writes dropped) without any s_* activity.
//   Ports:
//     clock, reset            : clock, synchronous active-low reset
//     m0_ar*/m0_r*            : IFU read request / accept pulse / data pulse
//     m1_ar*/m1_r*            : LSU read request / accept pulse / data pulse
//     m1_aw*/m1_w*/m1_bvalid  : LSU write (address+data together) / done pulse
//     s_ar*/s_r*              : downstream read channel
//     s_aw*/s_w*/s_bvalid     : downstream write channel
//     xbar_decode             : target select, held for the whole transaction
// ----------------------------------------------------------------------------
module ysyx_22050499_axi_arbiter
    import ysyx_22050499_axi_arbiter_pkg::*;
#(
    parameter logic [31:0] CLINT_BASE = CLINT_BASE_DEFAULT,
    parameter logic [31:0] CLINT_SIZE = CLINT_SIZE_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    // master 0 (IFU)
    input  logic        m0_arvalid,
    input  logic [31:0] m0_araddr,
    output logic        m0_arready,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    // master 1 (LSU)
    input  logic        m1_arvalid,
    input  logic [31:0] m1_araddr,
    output logic        m1_arready,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    input  logic        m1_awvalid,
    input  logic [31:0] m1_awaddr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_awready,
    output logic        m1_bvalid,
    // slave side
    output logic        s_arvalid,
    output logic [31:0] s_araddr,
    input  logic        s_arready,
    input  logic        s_rvalid,
    input  logic [31:0] s_rdata,
    output logic        s_awvalid,
    output logic [31:0] s_awaddr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_awready,
    input  logic        s_bvalid,
    output logic [3:0]  xbar_decode
);

    arb_state_t  state_reg;
    logic        owner_reg;
    logic        last_owner_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  wstrb_reg;
    logic [3:0]  decode_reg;
    logic        s_arvalid_reg;
    logic        s_awvalid_reg;
    logic        m0_rvalid_reg;
    logic [31:0] m0_rdata_reg;
    logic        m1_rvalid_reg;
    logic [31:0] m1_rdata_reg;
    logic        m1_bvalid_reg;

    logic        idle;
    logic        cand0;
    logic        cand1;
    logic        grant0;
    logic        grant1;
    logic        grant_any;
    logic        req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_decode;
    logic        req_mapped;

    // Arbitration. The accept pulses are combinational so a request is taken
    // in the same IDLE cycle it is seen; they are masked while reset is held
    // so every output reads 0 during reset.
    always_comb begin
        idle      = (state_reg == ST_IDLE) && reset;
        cand0     = m0_arvalid;
        cand1     = m1_awvalid | m1_arvalid;
        // On a tie the master that did not own the last transaction wins.
        grant0    = idle && cand0 && (!cand1 || last_owner_reg);
        grant1    = idle && cand1 && (!cand0 || !last_owner_reg);
        grant_any = grant0 | grant1;
        // Inside the LSU a pending write is served before a pending read.
        req_write = grant1 && m1_awvalid;
        if (grant1) begin
            req_addr = m1_awvalid ? m1_awaddr : m1_araddr;
        end else begin
            req_addr = m0_araddr;
        end
    end

    ysyx_22050499_addr_decode #(
        .CLINT_BASE (CLINT_BASE),
        .CLINT_SIZE (CLINT_SIZE)
    ) u_addr_decode (
        .addr   (req_addr),
        .decode (req_decode),
        .mapped (req_mapped)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= 1'b0;
            last_owner_reg <= 1'b1;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            wstrb_reg      <= '0;
            decode_reg     <= DECODE_NONE;
            s_arvalid_reg  <= 1'b0;
            s_awvalid_reg  <= 1'b0;
            m0_rvalid_reg  <= 1'b0;
            m0_rdata_reg   <= '0;
            m1_rvalid_reg  <= 1'b0;
            m1_rdata_reg   <= '0;
            m1_bvalid_reg  <= 1'b0;
        end else begin
            // Response strobes are single-cycle pulses.
            m0_rvalid_reg <= 1'b0;
            m1_rvalid_reg <= 1'b0;
            m1_bvalid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_any) begin
                        owner_reg      <= grant1;
                        last_owner_reg <= grant1;
                        addr_reg       <= req_addr;
                        decode_reg     <= req_decode;
                        if (req_write) begin
                            wdata_reg <= m1_wdata;
                            wstrb_reg <= m1_wstrb;
                        end
                        if (req_write && req_mapped) begin
                            state_reg     <= ST_AW;
                            s_awvalid_reg <= 1'b1;
                        end else if (req_write) begin
                            state_reg <= ST_ERR_B;
                        end else if (req_mapped) begin
                            state_reg     <= ST_AR;
                            s_arvalid_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_ERR_R;
                        end
                    end
                end
                ST_AR: begin
                    if (s_arready) begin
                        s_arvalid_reg <= 1'b0;
                        state_reg     <= ST_R;
                    end
                end
                ST_R: begin
                    if (s_rvalid) begin
                        if (owner_reg) begin
                            m1_rvalid_reg <= 1'b1;
                            m1_rdata_reg  <= s_rdata;
                        end else begin
                            m0_rvalid_reg <= 1'b1;
                            m0_rdata_reg  <= s_rdata;
                        end
                        decode_reg <= DECODE_NONE;
                        state_reg  <= ST_IDLE;
                    end
                end
                ST_AW: begin
                    if (s_awready) begin
                        s_awvalid_reg <= 1'b0;
                        state_reg     <= ST_B;
                    end
                end
                ST_B: begin
                    if (s_bvalid) begin
                        m1_bvalid_reg <= 1'b1;
                        decode_reg    <= DECODE_NONE;
                        state_reg     <= ST_IDLE;
                    end
                end
                ST_ERR_R: begin
                    // Unmapped read: answer locally with zero data.
                    if (owner_reg) begin
                        m1_rvalid_reg <= 1'b1;
                        m1_rdata_reg  <= '0;
                    end else begin
                        m0_rvalid_reg <= 1'b1;
                        m0_rdata_reg  <= '0;
                    end
                    decode_reg <= DECODE_NONE;
                    state_reg  <= ST_IDLE;
                end
                ST_ERR_B: begin
                    // Unmapped write: the data is dropped, completion still reported.
                    m1_bvalid_reg <= 1'b1;
                    decode_reg    <= DECODE_NONE;
                    state_reg     <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign m0_arready  = grant0;
    assign m1_arready  = grant1 && !m1_awvalid;
    assign m1_awready  = grant1 && m1_awvalid;
    assign m0_rvalid   = m0_rvalid_reg;
    assign m0_rdata    = m0_rdata_reg;
    assign m1_rvalid   = m1_rvalid_reg;
    assign m1_rdata    = m1_rdata_reg;
    assign m1_bvalid   = m1_bvalid_reg;
    assign s_arvalid   = s_arvalid_reg;
    assign s_araddr    = addr_reg;
    assign s_awvalid   = s_awvalid_reg;
    assign s_awaddr    = addr_reg;
    assign s_wdata     = wdata_reg;
    assign s_wstrb     = wstrb_reg;
    assign xbar_decode = decode_reg;

endmodule

// File: doc/ysyx_22050499_axi_arbiter.md
# ysyx_22050499_axi_arbiter

Two-master to one-slave request arbiter in front of the xbar/slave mux. It shares the single downstream port between the IFU (read-only, master 0) and the LSU (read/write, master 1). It serialises one outstanding transaction at a time and decodes the captured address into `xbar_decode`. Unmapped addresses are answered locally, so the slave side never sees them.

## Interface
- `CLINT_BASE`, default 32'ha000_0048: first byte address of the CLINT window.
- `CLINT_SIZE`, default 16: CLINT window size in bytes.

Clock and reset:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-low.

Master 0 (IFU, read-only):
- `m0_arvalid` in 1: IFU read request.
- `m0_araddr` in 32: IFU read address.
- `m0_arready` out 1: one-cycle accept pulse.
- `m0_rvalid` out 1: one-cycle read-data pulse.
- `m0_rdata` out 32: read data.

Master 1 (LSU, read/write):
- `m1_arvalid` in 1: LSU read request.
- `m1_araddr` in 32: LSU read address.
- `m1_arready` out 1: accept pulse.
- `m1_rvalid` out 1: read-data pulse.
- `m1_rdata` out 32: read data.
- `m1_awvalid` in 1: LSU write request; address and data travel together.
- `m1_awaddr` in 32: write address.
- `m1_wdata` in 32: write data.
- `m1_wstrb` in 4: byte strobes.
- `m1_awready` out 1: write accept pulse.
- `m1_bvalid` out 1: write-done pulse.

Slave side:
- `s_arvalid` out 1: downstream read request.
- `s_araddr` out 32: downstream read address.
- `s_arready` in 1: downstream read accept.
- `s_rvalid` in 1: downstream read data valid.
- `s_rdata` in 32: downstream read data.
- `s_awvalid` out 1: downstream write request.
- `s_awaddr` out 32: write address.
- `s_wdata` out 32: write data.
- `s_wstrb` out 4: write strobes.
- `s_awready` in 1: downstream write accept.
- `s_bvalid` in 1: downstream write done.
- `xbar_decode` out 4: 4'b0001 selects CLINT; 4'b0000 means none.

## Operation
- **FSM states:** IDLE, AR, R, AW, B, ERR_R, ERR_B.
- **Registers:** owner (0/1), last_owner, latched addr/wdata/wstrb, decode.
- **Arbitration in IDLE:**
  - Candidates are m0 (`m0_arvalid`) and m1 (`m1_awvalid` or `m1_arvalid`).
  - If only one candidate requests, it wins.
  - If both request, the master that is not last_owner wins.
  - Within m1, a write beats a read.
- **Grant (same IDLE cycle):**
  - Pulse the winner's `arready`/`awready` combinationally.
  - Latch the request, set owner and last_owner, register `xbar_decode`.
- **Decode:** the window is `CLINT_BASE <= addr < CLINT_BASE+CLINT_SIZE`, compared on the full 32 bits.
- **Mapped read:** AR drives `s_arvalid` until `s_arready` → R. R waits for `s_rvalid`, forwards `s_rdata` to the owner as a one-cycle `rvalid` → IDLE.
- **Mapped write:** AW drives `s_awvalid` and the write fields until `s_awready` → B. B waits for `s_bvalid`, pulses `m1_bvalid` → IDLE.
- **Unmapped read:** ERR_R; the next cycle pulses owner `rvalid` with `rdata` = 32'h0 → IDLE. No `s_*` activity.
- **Unmapped write:** ERR_B; the next cycle pulses `m1_bvalid` → IDLE. The write is dropped.
- **Master side:** masters always accept; there is no rready/bready.
- **Requests while busy:** held requests stay pending and are not accepted until IDLE.
- **Decode hold:** `xbar_decode` holds from grant until the return to IDLE, then clears to 0.

## Timing
- **Reset (`reset`=0 at a clock edge):**
  - State IDLE; all outputs 0, including `xbar_decode`.
  - last_owner is set to 1, so the IFU wins the first tie.
  - Applies mid-transaction: any in-flight response is discarded.
- **Grant latency:** 0 cycles (combinational accept in IDLE). `s_arvalid`/`s_awvalid` assert the cycle after the grant.
- **Unmapped response:** `rvalid`/`bvalid` at grant+2.
- **Mapped response:** arrives on the cycle `s_rvalid`/`s_bvalid` is seen in R/B, and is registered one cycle later to the master.
- **Throughput:** minimum 1 IDLE cycle between transactions; back-to-back requests from both masters alternate.
- **Spurious slave signals:** `s_rvalid` or `s_bvalid` outside R/B is ignored.

## Structure
- Shared package holds the state encoding, the decode constants (4'b0001 = CLINT, 4'b0000 = none) and `CLINT_BASE`/`CLINT_SIZE` defaults.
- One sub-module, `ysyx_22050499_addr_decode`: combinational address → `xbar_decode` plus a mapped flag. It is reusable when SRAM/UART return to the xbar.

## Test plan
- **IFU-only read:** `m0_araddr`=0xa000_0048, slave returns 0x1234_5678 → `m0_arready` at T, `s_arvalid` at T+1, `xbar_decode`=0001, `m0_rvalid`/`m0_rdata`=0x1234_5678 once.
- **Tie after reset:** m0 and m1 both read in the same cycle → m0 is granted first, m1 next; a repeat tie grants m1 first.
- **LSU write:** `m1_awaddr`=0xa000_004c, `wstrb`=4'b0011 → `s_awaddr`/`s_wstrb` match, and `m1_bvalid` pulses once after `s_bvalid`.
- **Unmapped read:** `m1_araddr`=0x8000_0000 → no `s_arvalid`, `xbar_decode`=0000, `m1_rvalid` at grant+2 with `rdata` 0.
- **Boundary decode:** 0xa000_0057 maps; 0xa000_0058 and 0xa000_0047 are unmapped.
- **Reset mid-transaction:** `reset` low while in R → next cycle all outputs are 0; a later `s_rvalid` produces no `m*_rvalid`.
